// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control types and constants (state encoding, NOP, register index width)
package pipe_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    LSTALL = 2'd2
  } state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hit; in load_dec/load_rd/rs1/rs2/use_rs1/use_rs2, out rd_hit
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             load_dec,
  input  logic [REG_W-1:0] load_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic             rd_hit
);
  assign rd_hit = load_dec && (load_rd != '0) &&
                  ((use_rs1 && rs1 == load_rd) || (use_rs2 && rs2 == load_rd));
endmodule

// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl: stall/flush sequencer; in clk/rst(async low)/jal/jalr/branch_taken/load_dec/load_rd/fe_rs1/fe_rs2/fe_use_rs1/fe_use_rs2/mem_wait, out pc_en/redirect/fe_hold/fe_flush/de_bubble/busy/stall_cnt
module fetch_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES      = 3,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jal,
  input  logic             jalr,
  input  logic             branch_taken,
  input  logic             load_dec,
  input  logic [REG_W-1:0] load_rd,
  input  logic [REG_W-1:0] fe_rs1,
  input  logic [REG_W-1:0] fe_rs2,
  input  logic             fe_use_rs1,
  input  logic             fe_use_rs2,
  input  logic             mem_wait,
  output logic             pc_en,
  output logic             redirect,
  output logic             fe_hold,
  output logic             fe_flush,
  output logic             de_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [3:0] FL_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic [3:0] LS_INIT = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
  localparam state_t FL_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
  localparam state_t LS_NEXT = (LOAD_STALL_CYCLES > 1) ? LSTALL : RUN;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic rd_hit, redir;
  assign redir = jal | jalr | branch_taken;
  assign busy = state != RUN;
  load_use_detect u_lud (
    .load_dec(load_dec),
    .load_rd (load_rd),
    .rs1     (fe_rs1),
    .rs2     (fe_rs2),
    .use_rs1 (fe_use_rs1),
    .use_rs2 (fe_use_rs2),
    .rd_hit  (rd_hit)
  );
  always_comb begin
    pc_en = 1'b1;
    redirect = 1'b0;
    fe_hold = 1'b0;
    fe_flush = 1'b0;
    de_bubble = 1'b0;
    state_n = state;
    cnt_n = cnt;
    if (!rst) begin
      pc_en = 1'b0;
      fe_flush = 1'b1;
      de_bubble = 1'b1;
    end else if (mem_wait) begin
      pc_en = 1'b0;
      fe_hold = 1'b1;
    end else if (redir) begin
      redirect = 1'b1;
      fe_flush = 1'b1;
      state_n = FL_NEXT;
      cnt_n = FL_INIT;
    end else if (state != RUN) begin
      pc_en = state == FLUSH;
      fe_flush = state == FLUSH;
      fe_hold = state != FLUSH;
      de_bubble = state != FLUSH;
      state_n = (cnt == 4'd0) ? RUN : state;
      cnt_n = (cnt == 4'd0) ? cnt : cnt - 4'd1;
    end else if (rd_hit) begin
      pc_en = 1'b0;
      fe_hold = 1'b1;
      de_bubble = 1'b1;
      state_n = LS_NEXT;
      cnt_n = LS_INIT;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt <= 4'd0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      stall_cnt <= stall_cnt + CNT_W'(!pc_en);
    end
  end
endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb_fetch_hazard_ctrl: directed vector table plus corner sequences for fetch_hazard_ctrl
module tb_fetch_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic jal = 0, jalr = 0, branch_taken = 0, load_dec = 0, mem_wait = 0, fe_use_rs1 = 0, fe_use_rs2 = 0;
  logic [4:0] load_rd = 0, fe_rs1 = 0, fe_rs2 = 0;
  logic pe1, rd1, fh1, ff1, db1, bz1, pe3, rd3, fh3, ff3, db3, bz3;
  logic [31:0] sc1, sc3;
  logic [5:0] o1, o3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign o1 = {pe1, rd1, fh1, ff1, db1, bz1};
  assign o3 = {pe3, rd3, fh3, ff3, db3, bz3};
  fetch_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .jal(jal), .jalr(jalr), .branch_taken(branch_taken),
    .load_dec(load_dec), .load_rd(load_rd), .fe_rs1(fe_rs1), .fe_rs2(fe_rs2),
    .fe_use_rs1(fe_use_rs1), .fe_use_rs2(fe_use_rs2), .mem_wait(mem_wait),
    .pc_en(pe1), .redirect(rd1), .fe_hold(fh1), .fe_flush(ff1), .de_bubble(db1),
    .busy(bz1), .stall_cnt(sc1)
  );
  fetch_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .jal(jal), .jalr(jalr), .branch_taken(branch_taken),
    .load_dec(load_dec), .load_rd(load_rd), .fe_rs1(fe_rs1), .fe_rs2(fe_rs2),
    .fe_use_rs1(fe_use_rs1), .fe_use_rs2(fe_use_rs2), .mem_wait(mem_wait),
    .pc_en(pe3), .redirect(rd3), .fe_hold(fh3), .fe_flush(ff3), .de_bubble(db3),
    .busy(bz3), .stall_cnt(sc3)
  );
  // expected output vectors: {pc_en, redirect, fe_hold, fe_flush, de_bubble, busy}
  localparam logic [5:0] N = 6'b100000, J = 6'b110100, F = 6'b100101, S = 6'b001010;
  localparam logic [5:0] W = 6'b001000, JB = 6'b110101, LS = 6'b001011, WF = 6'b001001, R = 6'b000110;
  typedef struct {
    logic [2:0] rdr;
    logic       ld;
    logic [4:0] lrd, rs1, rs2;
    logic       u1, u2, mw;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[22];
  function automatic vec_t mk(logic [2:0] rdr, logic ld, logic [4:0] lrd, rs1, rs2,
                              logic u1, u2, mw, logic [5:0] exp);
    vec_t v;
    v.rdr = rdr; v.ld = ld; v.lrd = lrd; v.rs1 = rs1; v.rs2 = rs2;
    v.u1 = u1; v.u2 = u2; v.mw = mw; v.exp = exp;
    return v;
  endfunction
  task automatic drive(vec_t v);
    {jal, jalr, branch_taken} = v.rdr;
    load_dec = v.ld; load_rd = v.lrd; fe_rs1 = v.rs1; fe_rs2 = v.rs2;
    fe_use_rs1 = v.u1; fe_use_rs2 = v.u2; mem_wait = v.mw;
  endtask
  task automatic step(vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
  endtask
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, N));
    @(negedge clk);
    chk("reset_out", {26'd0, o1}, {26'd0, R});
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  vec_t idle, hit5, hit3;
  initial begin
    idle = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, N);
    hit5 = mk(3'b000, 1, 5, 0, 5, 0, 1, 0, S);
    hit3 = mk(3'b000, 1, 9, 9, 0, 1, 0, 0, S);
    vecs[0]  = idle;
    vecs[1]  = mk(3'b100, 0, 0, 0, 0, 0, 0, 0, J);
    vecs[2]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, F);
    vecs[3]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, F);
    vecs[4]  = idle;
    vecs[5]  = hit5;
    vecs[6]  = idle;
    vecs[7]  = mk(3'b000, 1, 0, 0, 0, 0, 1, 0, N);
    vecs[8]  = mk(3'b000, 1, 7, 7, 0, 0, 0, 0, N);
    vecs[9]  = mk(3'b000, 1, 7, 7, 0, 1, 0, 0, S);
    vecs[10] = mk(3'b010, 0, 0, 0, 0, 0, 0, 0, J);
    vecs[11] = mk(3'b000, 1, 5, 0, 5, 0, 1, 0, F);
    vecs[12] = mk(3'b100, 0, 0, 0, 0, 0, 0, 0, JB);
    vecs[13] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, F);
    vecs[14] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, F);
    vecs[15] = idle;
    vecs[16] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, W);
    vecs[17] = mk(3'b100, 1, 5, 0, 5, 0, 1, 1, W);
    vecs[18] = mk(3'b001, 0, 0, 0, 0, 0, 0, 0, J);
    vecs[19] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, F);
    vecs[20] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, F);
    vecs[21] = idle;
    @(negedge clk);
    chk("reset_out0", {26'd0, o1}, {26'd0, R});
    chk("reset_cnt0", sc1, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step(vecs[i]);
      chk($sformatf("vec%0d", i), {26'd0, o1}, {26'd0, vecs[i].exp});
    end
    @(posedge clk);
    #1;
    chk("table_stall_cnt", sc1, 32'd4);
    // reset asserted while FLUSH has cnt=1
    do_reset();
    step(mk(3'b100, 0, 0, 0, 0, 0, 0, 0, J));
    chk("rf_jal", {26'd0, o1}, {26'd0, J});
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(idle);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rf_in_reset", {26'd0, o1}, {26'd0, R});
      chk("rf_cnt_reset", sc1, 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rf_after", {26'd0, o1}, {26'd0, N});
      @(posedge clk);
      #1;
    end
    chk("rf_cnt_after", sc1, 32'd0);
    // three-cycle load stall, then redirect out of LSTALL
    do_reset();
    step(hit3);
    chk("ls3_hit", {26'd0, o3}, {26'd0, S});
    step(idle);
    chk("ls3_c2", {26'd0, o3}, {26'd0, LS});
    step(idle);
    chk("ls3_c3", {26'd0, o3}, {26'd0, LS});
    step(idle);
    chk("ls3_run", {26'd0, o3}, {26'd0, N});
    @(posedge clk);
    #1;
    chk("ls3_stall_cnt", sc3, 32'd3);
    step(hit3);
    chk("lsb_hit", {26'd0, o3}, {26'd0, S});
    step(mk(3'b001, 0, 0, 0, 0, 0, 0, 0, N));
    chk("lsb_br", {26'd0, o3}, {26'd0, JB});
    step(idle);
    chk("lsb_f1", {26'd0, o3}, {26'd0, F});
    step(idle);
    chk("lsb_f2", {26'd0, o3}, {26'd0, F});
    step(idle);
    chk("lsb_run", {26'd0, o3}, {26'd0, N});
    // mem_wait freezes FLUSH at cnt=1, redirect ignored
    do_reset();
    step(mk(3'b100, 0, 0, 0, 0, 0, 0, 0, J));
    chk("mw_jal", {26'd0, o1}, {26'd0, J});
    for (int i = 0; i < 4; i++) begin
      step(mk((i == 1) ? 3'b010 : 3'b000, 0, 0, 0, 0, 0, 0, 1, WF));
      chk($sformatf("mw_wait%0d", i), {26'd0, o1}, {26'd0, WF});
    end
    step(idle);
    chk("mw_f1", {26'd0, o1}, {26'd0, F});
    step(idle);
    chk("mw_f2", {26'd0, o1}, {26'd0, F});
    step(idle);
    chk("mw_run", {26'd0, o1}, {26'd0, N});
    @(posedge clk);
    #1;
    chk("mw_stall_cnt", sc1, 32'd4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 3-stage RV32I pipeline.
- Decides each cycle whether the PC advances, whether the fetch/decode pipeline register loads, holds or is cleared, and whether a bubble goes into the execute stage.
- Handles three hazard sources: control redirects (jal, jalr, taken branch), load-use hazards, and data-memory wait.
- Also keeps a free-running stall-cycle performance counter.

Parameters:
- FLUSH_CYCLES, 3: total bubble cycles after a redirect, including the redirect cycle itself. Legal range 1..15.
- LOAD_STALL_CYCLES, 1: hold cycles per load-use hazard, including the detect cycle. Legal range 1..15.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- jal  in  1  decode stage holds a jal
- jalr  in  1  decode stage holds a jalr
- branch_taken  in  1  branch in decode resolved taken
- load_dec  in  1  decode stage holds a load
- load_rd  in  5  destination register of that load
- fe_rs1  in  5  rs1 of the instruction in the fetch register
- fe_rs2  in  5  rs2 of the instruction in the fetch register
- fe_use_rs1  in  1  fetch instruction reads rs1
- fe_use_rs2  in  1  fetch instruction reads rs2
- mem_wait  in  1  data memory not ready; freeze the pipeline
- pc_en  out  1  PC register load enable
- redirect  out  1  PC mux selects the branch/jump target
- fe_hold  out  1  fetch register keeps its current contents
- fe_flush  out  1  fetch register loads zero (NOP bubble)
- de_bubble  out  1  zero the decode-to-execute control signals this cycle
- busy  out  1  state is not RUN
- stall_cnt  out  CNT_W  count of cycles with pc_en=0 since reset; wraps at 2^CNT_W

Behaviour:
- States: RUN, FLUSH, LSTALL. One down-counter `cnt`, 4 bits wide.
- Definitions:
  - `rd_hit` = load_dec & (load_rd != 0) & ((fe_use_rs1 & fe_rs1 == load_rd) | (fe_use_rs2 & fe_rs2 == load_rd)).
  - `redir` = jal | jalr | branch_taken.
- While rst is low: state=RUN, cnt=0, stall_cnt=0. Outputs are forced to pc_en=0, redirect=0, fe_hold=0, fe_flush=1, de_bubble=1, busy=0.
- Reset asserted mid-flush or mid-stall aborts immediately. There is no residual bubble after release.
- Priority, evaluated every cycle: mem_wait > redir > state activity > rd_hit > normal run.
- mem_wait=1, any state:
  - pc_en=0, fe_hold=1, fe_flush=0, redirect=0, de_bubble=0.
  - State and cnt hold. redir and rd_hit are ignored; the source stage is frozen, so they re-present later.
- RUN:
  - If redir: redirect=1, pc_en=1, fe_flush=1, de_bubble=0. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
  - Else if rd_hit: pc_en=0, fe_hold=1, de_bubble=1. If LOAD_STALL_CYCLES>1, go to LSTALL with cnt=LOAD_STALL_CYCLES-2; otherwise stay in RUN.
  - Else: pc_en=1, with all other outputs 0.
- FLUSH:
  - pc_en=1, fe_flush=1, redirect=0, de_bubble=0.
  - rd_hit is ignored, because bubbles carry no registers.
  - A redir arriving here restarts the sequence exactly as it would from RUN.
  - If cnt==0, go to RUN; else decrement cnt.
- LSTALL:
  - pc_en=0, fe_hold=1, de_bubble=1.
  - A redir here wins: apply the RUN-redir action and go to FLUSH (or RUN when FLUSH_CYCLES=1).
  - Otherwise, if cnt==0, go to RUN; else decrement cnt.
- Invariants: fe_hold and fe_flush are never both 1, and redirect implies pc_en=1.
- Outputs are combinational decodes of state, cnt and inputs, so a redirect and the first bubble occur on the same edge. There is zero-cycle latency from redir to fe_flush.
- stall_cnt increments on every clock edge out of reset where pc_en=0.
- Default bubble sequence for a jump in RUN: bubbles on cycles N, N+1, N+2; the first real fetch register load happens on the edge at the end of cycle N+3.

Decomposition:
- Shared package `pipe_ctrl_pkg` holds:
  - the state encoding: RUN=2'd0, FLUSH=2'd1, LSTALL=2'd2;
  - the `NOP_INSTR` = 32'h0000_0000 constant;
  - the register-index width constant of 5.
- One sub-module, `load_use_detect`, is natural: a purely combinational rd_hit comparator, reusable by a future forwarding unit.
- The FSM, counter and perf counter stay in the top module.

Test Plan:
- Reset low mid-FLUSH (cnt=1), released after 2 cycles -> fe_flush=1 and pc_en=0 during reset; state=RUN, stall_cnt=0 after release, and no further bubbles.
- jal=1 for one cycle in RUN, defaults -> fe_flush=1 for exactly 3 consecutive cycles, redirect=1 only in the first of them; pc_en=1 throughout; busy=1 for cycles 2–3.
- load_dec=1, load_rd=5, fe_rs2=5, fe_use_rs2=1 -> pc_en=0, fe_hold=1, de_bubble=1 for 1 cycle; stall_cnt increments by 1. Repeat with load_rd=0 -> no stall.
- branch_taken=1 in LSTALL with LOAD_STALL_CYCLES=3 and cnt=1 -> same cycle: redirect=1, fe_flush=1, fe_hold=0; then 2 more flush cycles.
- mem_wait=1 for 4 cycles during FLUSH with cnt=1, jalr pulsed meanwhile -> fe_hold=1 and pc_en=0 for those 4 cycles; cnt stays 1; after release, exactly 2 flush cycles remain; stall_cnt +4.
- jal re-asserted on the last FLUSH cycle -> counter restarts; 3 further bubble cycles follow.
